uart_tx_scheduler: RTL

Round-robin transmit scheduler that shares one UART_Transmitter between N_REQ requesters. Arbitrates pending 32-bit words and drives the transmitter's Tx_start and Data_In. Because the transmitter reports no completion, the scheduler times each frame with a baud-tick counter. It sits directly above UART_Transmitter, clocked by the same Baud_Clk.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rr_picker.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit scheduler
package uart_pkg;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_FRAME_CYCLES = 35;
    localparam int DEF_GAP_CYCLES   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_e;

    // Bits needed to index 'value' distinct items; 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - rotate-priority encoder: first set req bit at or after rr_ptr
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int  N_REQ = DEF_N_REQ,
    localparam int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             valid,
    output logic [ID_W-1:0]  index
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest offset down so the nearest set bit is written last.
    // N_REQ is a power of two, so the ID_W-bit sum wraps naturally.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = rr_ptr + ID_W'(i);
            if (req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler feeding one UART transmitter, frame-timed by cycle count
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int  N_REQ        = DEF_N_REQ,
    parameter int  DATA_W       = DEF_DATA_W,
    parameter int  FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int  GAP_CYCLES   = DEF_GAP_CYCLES,
    localparam int ID_W         = clog2(N_REQ)
) (
    input  logic                    Baud_Clk,
    input  logic                    Reset,
    input  logic                    Tx_enable,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] Req_Data,
    output logic [N_REQ-1:0]        Ack,
    output logic [ID_W-1:0]         Grant_Id,
    output logic                    Tx_start,
    output logic [DATA_W-1:0]       Tx_Data,
    output logic                    Busy
);

    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = clog2(CNT_MAX + 1);

    tx_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               tx_start_q, tx_start_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;

    uart_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (Req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    // Ack/Tx_start default low so each grant produces exactly one pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: begin
                if (Tx_enable && pick_valid) begin
                    tx_data_d  = Req_Data[pick_idx*DATA_W +: DATA_W];
                    grant_id_d = pick_idx;
                    ack_d      = N_REQ'(1) << pick_idx;
                    tx_start_d = 1'b1;
                    cnt_d      = CNT_W'(FRAME_CYCLES - 1);
                    rr_ptr_d   = pick_idx + ID_W'(1);
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Baud_Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            grant_id_q <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign Ack      = ack_q;
    assign Grant_Id = grant_id_q;
    assign Tx_start = tx_start_q;
    assign Tx_Data  = tx_data_q;
    assign Busy     = (state_q != IDLE);

endmodule
